// File: rtl/counter_pkg.sv
// Shared constants and op decoding for the up/down counter family.
// Direction and mode encodings match the raw up_dn / sat_mode pin levels.
package counter_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic CNT_UP    = 1'b1;
   localparam logic CNT_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_UP   = 2'd2,
      OP_DOWN = 2'd3
   } cnt_op_e;

   // Load outranks enable; direction only matters when counting.
   function automatic cnt_op_e decode_op(input logic load, input logic en, input logic up_dn);
      cnt_op_e op;
      if (load)
         op = OP_LOAD;
      else if (!en)
         op = OP_HOLD;
      else if (up_dn == CNT_DOWN)
         op = OP_DOWN;
      else
         op = OP_UP;
      return op;
   endfunction

endpackage

// File: rtl/d_flipflop.sv
// Single-bit D flip-flop with asynchronous active-low reset to a per-instance value.
module d_flipflop #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         q <= RESET_VAL;
      else
         q <= d;
   end

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down counter bounded to 0..limit with wrap or saturate behaviour.
// State lives in per-bit d_flipflop instances; one comb block computes the next state.
module updown_counter
   import counter_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             up_dn,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             wrap_pulse,
   output logic             at_max,
   output logic             at_zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrap_q;
   logic             wrap_d;
   cnt_op_e          op;

   assign op = decode_op(load, en, up_dn);

   // Increment only happens when count_q < limit, so it can never carry out of WIDTH bits.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      unique case (op)
         OP_LOAD: begin
            count_d = (load_data > limit) ? limit : load_data;
         end
         OP_UP: begin
            if (count_q < limit) begin
               count_d = count_q + WIDTH'(1);
            end else if (sat_mode == MODE_SAT) begin
               count_d = limit;
            end else begin
               count_d = '0;
               wrap_d  = 1'b1;
            end
         end
         OP_DOWN: begin
            if (count_q != '0) begin
               count_d = count_q - WIDTH'(1);
            end else if (sat_mode == MODE_WRAP) begin
               count_d = limit;
               wrap_d  = 1'b1;
            end
         end
         default: begin
            count_d = count_q;
         end
      endcase
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_count_ff
      d_flipflop #(
         .RESET_VAL (RESET_VAL[i])
      ) u_count_ff (
         .clk     (clk),
         .reset_n (reset_n),
         .d       (count_d[i]),
         .q       (count_q[i])
      );
   end

   d_flipflop #(
      .RESET_VAL (1'b0)
   ) u_wrap_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (wrap_d),
      .q       (wrap_q)
   );

   assign count      = count_q;
   assign wrap_pulse = wrap_q;
   assign at_max     = (count_q >= limit);
   assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Randomised and directed bench for updown_counter with a queued scoreboard.
module tb_updown_counter;

   localparam int W    = 8;
   localparam int RVAL = 0;
   localparam int MAXV = (1 << W) - 1;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic         wrap;
      logic         amax;
      logic         azero;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         en;
   logic         load;
   logic [W-1:0] load_data;
   logic         up_dn;
   logic         sat_mode;
   logic [W-1:0] limit;
   logic [W-1:0] count;
   logic         wrap_pulse;
   logic         at_max;
   logic         at_zero;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   mc     = RVAL;

   updown_counter #(
      .WIDTH     (W),
      .RESET_VAL (W'(RVAL))
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .en         (en),
      .load       (load),
      .load_data  (load_data),
      .up_dn      (up_dn),
      .sat_mode   (sat_mode),
      .limit      (limit),
      .count      (count),
      .wrap_pulse (wrap_pulse),
      .at_max     (at_max),
      .at_zero    (at_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every sampled cycle with a pending expectation is compared.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("count", int'(count), int'(e.cnt));
         check("wrap_pulse", int'(wrap_pulse), int'(e.wrap));
         check("at_max", int'(at_max), int'(e.amax));
         check("at_zero", int'(at_zero), int'(e.azero));
      end
   end

   // Reference: integer counter over 0..lim following the stated rules.
   task automatic apply(input bit e, input bit ld, input int ldd, input bit up, input bit sat, input int lim);
      exp_t x;
      bit   w = 0;
      en = e; load = ld; load_data = W'(ldd); up_dn = up; sat_mode = sat; limit = W'(lim);
      if (ld) begin
         mc = (ldd < lim) ? ldd : lim;
      end else if (e && up) begin
         if (mc < lim) mc = mc + 1;
         else if (sat) mc = lim;
         else begin mc = 0; w = 1; end
      end else if (e) begin
         if (mc > 0) mc = mc - 1;
         else if (!sat) begin mc = lim; w = 1; end
      end
      x.cnt = W'(mc); x.wrap = w; x.amax = (mc >= lim); x.azero = (mc == 0);
      exp_q.push_back(x);
   endtask

   task automatic drive(input bit e, input bit ld, input int ldd, input bit up, input bit sat, input int lim);
      @(negedge clk);
      #1;
      apply(e, ld, ldd, up, sat, lim);
   endtask

   // Reset between edges, held across one rising edge, then released with counting enabled.
   task automatic async_reset(input int lim);
      @(negedge clk);
      #1;
      en = 1'b1; load = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("reset_count_async", int'(count), RVAL);
      check("reset_wrap_async", int'(wrap_pulse), 0);
      @(negedge clk);
      check("reset_count_held", int'(count), RVAL);
      check("reset_wrap_held", int'(wrap_pulse), 0);
      #1;
      reset_n = 1'b1;
      mc = RVAL;
      apply(1, 0, 0, 1, 0, lim);
   endtask

   initial begin
      int lim;
      bit sat;
      reset_n = 1'b0; en = 1'b0; load = 1'b0; load_data = '0;
      up_dn = 1'b1; sat_mode = 1'b0; limit = W'(9);
      #1;
      check("por_count", int'(count), RVAL);
      check("por_wrap", int'(wrap_pulse), 0);
      check("por_at_zero", int'(at_zero), 1);
      @(negedge clk);
      #1;
      reset_n = 1'b1;

      // Up wrap at limit 9 for 12 cycles.
      for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 0, 9);
      // Down saturate from 3.
      drive(0, 1, 3, 1, 0, 9);
      for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 1, 9);
      // Load clamp, then load beating enable.
      drive(0, 1, 200, 1, 0, 9);
      drive(1, 1, 4, 1, 0, 9);
      // Dynamic limit lowered below current count.
      drive(0, 1, 15, 1, 0, 20);
      drive(1, 0, 0, 1, 0, 10);
      drive(0, 1, 15, 1, 0, 20);
      drive(1, 0, 0, 0, 0, 10);
      drive(1, 0, 0, 0, 1, 10);
      // Async reset at count 7, and again right after a wrap.
      drive(0, 1, 7, 1, 0, 20);
      async_reset(20);
      drive(0, 1, 9, 1, 0, 9);
      drive(1, 0, 0, 1, 0, 9);
      async_reset(9);
      drive(0, 0, 0, 1, 0, 9);
      // Full range and limit 0.
      drive(0, 1, 254, 1, 0, MAXV);
      for (int i = 0; i < 3; i++) drive(1, 0, 0, 1, 0, MAXV);
      drive(1, 0, 0, 0, 0, MAXV);
      for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) drive(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) drive(1, 0, 0, 1, 1, 0);

      // Random traffic; limit and mode change occasionally so bounds get hit.
      lim = 12; sat = 0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 9))
               0:       lim = 0;
               1:       lim = MAXV;
               2, 3:    lim = $urandom_range(1, 4);
               default: lim = $urandom_range(0, MAXV);
            endcase
         end
         if ($urandom_range(0, 15) == 0) sat = ~sat;
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, MAXV), $urandom_range(0, 1) == 1, sat, lim);
      end

      for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The module SHALL have parameter RESET_VAL, default 0, giving the count value after reset (must be < 2**WIDTH).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port en, input, 1 bit: count enable.
REQ-006 The module SHALL have port load, input, 1 bit: synchronous parallel load request.
REQ-007 The module SHALL have port load_data, input, WIDTH bits: value to load.
REQ-008 The module SHALL have port up_dn, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The module SHALL have port sat_mode, input, 1 bit: 1 = saturate at bounds, 0 = wrap.
REQ-010 The module SHALL have port limit, input, WIDTH bits: upper bound; legal range is 0..limit.
REQ-011 The module SHALL have port count, output, WIDTH bits: registered count value.
REQ-012 The module SHALL have port wrap_pulse, output, 1 bit: registered one-cycle pulse following a wrap event.
REQ-013 The module SHALL have port at_max, output, 1 bit: combinational (count >= limit).
REQ-014 The module SHALL have port at_zero, output, 1 bit: combinational (count == 0).

Function
REQ-015 Priority SHALL be load over en; with load=0 and en=0, count SHALL hold.
REQ-016 When load=1, count SHALL take min(load_data, limit) at the next edge, regardless of en, up_dn or sat_mode; wrap_pulse SHALL be 0 in that cycle.
REQ-017 When counting up (en=1, up_dn=1) with count < limit, count SHALL become count+1 at the next edge.
REQ-018 When counting up with count >= limit, count SHALL become 0 and wrap_pulse SHALL be 1 for the following cycle if sat_mode=0; if sat_mode=1, count SHALL become limit and wrap_pulse SHALL stay 0.
REQ-019 When counting down (en=1, up_dn=0) with count > 0, count SHALL become count-1; this includes count > limit, after a dynamic limit change.
REQ-020 When counting down with count == 0, count SHALL become limit and wrap_pulse SHALL be 1 for the following cycle if sat_mode=0; if sat_mode=1, count SHALL hold 0 and wrap_pulse SHALL stay 0.
REQ-021 With limit == 0, count SHALL remain 0 when enabled; in wrap mode, wrap_pulse SHALL assert every enabled cycle.
REQ-022 With limit == 2**WIDTH-1, behaviour SHALL equal a plain modulo-2**WIDTH counter, with no overflow beyond WIDTH bits.
REQ-023 All arithmetic SHALL be unsigned, WIDTH bits; the next-count computation SHALL NOT generate intermediate carries into count.
REQ-024 Changes to up_dn, sat_mode or limit SHALL take effect at the next edge with no pipeline delay.
REQ-025 wrap_pulse SHALL be 0 in any cycle not immediately following a wrap event; consecutive wrap events SHALL hold it high continuously.

Reset
REQ-026 While reset_n=0, count SHALL equal RESET_VAL and wrap_pulse SHALL equal 0, immediately and independent of clk.
REQ-027 Reset asserted mid-count SHALL abort the operation with no residual wrap_pulse after release.
REQ-028 On release, the first update SHALL occur at the first rising clk edge with reset_n=1.

Structure
REQ-029 A shared package counter_pkg SHALL define the direction constants CNT_UP=1 and CNT_DOWN=0, the mode constants MODE_WRAP=0 and MODE_SAT=1, and the default WIDTH.
REQ-030 State bits SHALL be built from the existing d_flipflop sub-module, using one generate-instantiated instance per count bit plus one for wrap_pulse.
REQ-031 Next-state logic SHALL be a single combinational block feeding the flip-flop D inputs.

Verification
REQ-032 Reset and up wrap: WIDTH=8, RESET_VAL=0, limit=9, up, wrap, en=1 for 12 cycles -> count 0..9, 0, 1; wrap_pulse high only in the cycle after 9->0.
REQ-033 Down saturate: limit=9, load 3, then down, sat_mode=1 for 5 cycles -> count 3, 2, 1, 0, 0, 0; wrap_pulse never high; at_zero=1 from the 0 value onward.
REQ-034 Load clamp: limit=9, load=1, load_data=200 -> count=9, at_max=1; load=1 with en=1 in the same cycle -> load wins.
REQ-035 Dynamic limit: count=15 with limit=20; set limit=10 and count up -> next count=0 with wrap_pulse; with down instead -> next count=14.
REQ-036 Async reset: assert reset_n=0 between edges while count=7 -> count=RESET_VAL and wrap_pulse=0 within the same cycle; release -> counting resumes at the next edge.
REQ-037 Full range and limit=0: limit=255, up from 254 -> 255, then 0 with wrap_pulse; limit=0 in wrap mode -> count stays 0 and wrap_pulse stays high.
